// File: rtl/jt89_bus.sv
// jt89_bus: SN76489-style host write port for the JT89 PSG.
// Decodes latch/data bytes into tone, volume and noise registers.
//
// Ports:
//   clk, rst      system clock, sync active-high reset
//   clk_en        chip enable; bus sampling and updates only here
//   din           host data byte
//   cs_n, wr_n    active-low chip select and write strobe
//   ready         1 = idle, 0 = absorbing a write
//   tone0..tone2  10-bit tone periods
//   vol0..vol3    attenuations (F = silent), vol3 is noise
//   ctrl3         noise control {white, rate[1:0]}
//   noise_clr     one-clk LFSR clear on every noise-control write

module jt89_bus #(
  parameter int BUSY_CYC = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] din,
  input  logic       cs_n,
  input  logic       wr_n,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       noise_clr
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     st;
  state_t     st_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  logic       wr_act;
  logic       wr_last;
  logic       accept;

  logic [1:0] lat_ch;
  logic       lat_typ;
  logic       is_latch;
  logic [1:0] tgt_ch;
  logic       tgt_typ;

  logic [2:0] we_tone;
  logic [3:0] we_vol;
  logic       we_ctrl;

  assign wr_act = ~cs_n & ~wr_n;
  assign ready  = (st == IDLE);

  // Edge-qualified strobe: a level held low never
  // re-triggers, and edges during BUSY are dropped.
  assign accept = clk_en & wr_act & ~wr_last & ready;

  // Data bytes reuse the last latched target.
  assign is_latch = din[7];
  assign tgt_ch   = is_latch ? din[6:5] : lat_ch;
  assign tgt_typ  = is_latch ? din[4]   : lat_typ;

  function automatic logic [9:0] tone_upd(
    input logic [9:0] cur,
    input logic [7:0] b
  );
    if (b[7])
      tone_upd = {cur[9:4], b[3:0]};
    else
      tone_upd = {b[5:0], cur[3:0]};
  endfunction

  always_comb begin
    we_tone = '0;
    we_vol  = '0;
    we_ctrl = 1'b0;
    if (accept) begin
      unique case (1'b1)
        tgt_typ: we_vol[tgt_ch] = 1'b1;
        (!tgt_typ && tgt_ch == 2'd3): we_ctrl = 1'b1;
        (!tgt_typ && tgt_ch != 2'd3): begin
          unique case (tgt_ch)
            2'd0:    we_tone[0] = 1'b1;
            2'd1:    we_tone[1] = 1'b1;
            default: we_tone[2] = 1'b1;
          endcase
        end
      endcase
    end
  end

  // Count reaches zero on the BUSY_CYC-th tick after
  // accept; ready is back high right after that edge.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    unique case (st)
      IDLE: begin
        if (accept) begin
          st_nxt  = BUSY;
          cnt_nxt = 8'(BUSY_CYC);
        end
      end
      BUSY: begin
        if (clk_en) begin
          cnt_nxt = cnt - 8'd1;
          if (cnt_nxt == 8'd0)
            st_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      cnt <= 8'd0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // wr_last=1 masks a strobe already low at reset exit.
      wr_last   <= 1'b1;
      lat_ch    <= 2'd0;
      lat_typ   <= 1'b0;
      tone0     <= 10'd0;
      tone1     <= 10'd0;
      tone2     <= 10'd0;
      vol0      <= 4'hF;
      vol1      <= 4'hF;
      vol2      <= 4'hF;
      vol3      <= 4'hF;
      ctrl3     <= 3'd0;
      noise_clr <= 1'b0;
    end else begin
      // Not gated by clk_en: always exactly one clk wide.
      noise_clr <= we_ctrl;
      if (clk_en)
        wr_last <= wr_act;
      if (accept && is_latch) begin
        lat_ch  <= din[6:5];
        lat_typ <= din[4];
      end
      if (we_tone[0]) tone0 <= tone_upd(tone0, din);
      if (we_tone[1]) tone1 <= tone_upd(tone1, din);
      if (we_tone[2]) tone2 <= tone_upd(tone2, din);
      if (we_vol[0])  vol0  <= din[3:0];
      if (we_vol[1])  vol1  <= din[3:0];
      if (we_vol[2])  vol2  <= din[3:0];
      if (we_vol[3])  vol3  <= din[3:0];
      if (we_ctrl)    ctrl3 <= din[2:0];
    end
  end

endmodule

// File: tb/tb_jt89_bus.sv
// tb_jt89_bus: randomized scoreboard bench for jt89_bus.
// Model predicts register state per accepted write.

module tb_jt89_bus;

  localparam int BC = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic [7:0] din = 8'h00;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       ready;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  logic       noise_clr;

  always #5 clk = ~clk;

  jt89_bus #(.BUSY_CYC(BC)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .din       (din),
    .cs_n      (cs_n),
    .wr_n      (wr_n),
    .ready     (ready),
    .tone0     (tone0),
    .tone1     (tone1),
    .tone2     (tone2),
    .vol0      (vol0),
    .vol1      (vol1),
    .vol2      (vol2),
    .vol3      (vol3),
    .ctrl3     (ctrl3),
    .noise_clr (noise_clr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model of the chip's programmer-visible state.
  logic [9:0] m_tone [4];
  logic [3:0] m_vol  [4];
  logic [2:0] m_ctrl;
  logic [1:0] m_ch;
  logic       m_typ;

  typedef struct {
    logic [9:0] t0, t1, t2;
    logic [3:0] v0, v1, v2, v3;
    logic [2:0] c;
    bit         nz;
  } exp_t;

  exp_t q[$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_tone[i] = 10'd0;
      m_vol[i]  = 4'hF;
    end
    m_ctrl = 3'd0;
    m_ch   = 2'd0;
    m_typ  = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] b, output bit nz);
    nz = 1'b0;
    if (b[7]) begin
      m_ch  = b[6:5];
      m_typ = b[4];
    end
    if (m_typ) begin
      m_vol[m_ch] = b[3:0];
    end else if (m_ch == 2'd3) begin
      m_ctrl = b[2:0];
      nz     = 1'b1;
    end else if (b[7]) begin
      m_tone[m_ch] = (m_tone[m_ch] & 10'h3F0) | 10'(b[3:0]);
    end else begin
      m_tone[m_ch] = (m_tone[m_ch] & 10'h00F) | (10'(b[5:0]) << 4);
    end
  endtask

  task automatic push_exp(input bit nz);
    exp_t e;
    e.t0 = m_tone[0]; e.t1 = m_tone[1]; e.t2 = m_tone[2];
    e.v0 = m_vol[0];  e.v1 = m_vol[1];
    e.v2 = m_vol[2];  e.v3 = m_vol[3];
    e.c  = m_ctrl;
    e.nz = nz;
    q.push_back(e);
  endtask

  // clk_en generator: inputs change 1 time unit after posedge.
  bit en_rand = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      clk_en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: an accept shows up as ready falling.
  bit prev_rdy = 1'b1;
  bit chk_low  = 1'b0;
  int ticks    = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rdy = 1'b1;
        ticks    = 0;
        chk_low  = 1'b0;
      end else begin
        if (chk_low) begin
          check("noise_width", noise_clr, 0);
          chk_low = 1'b0;
        end else if (!(prev_rdy && !ready) && noise_clr) begin
          check("noise_spurious", noise_clr, 0);
        end
        if (prev_rdy && !ready) begin
          ticks = 0;
          if (q.size() == 0) begin
            check("unexpected_accept", 0, 1);
          end else begin
            e = q.pop_front();
            check("tone0", tone0, e.t0);
            check("tone1", tone1, e.t1);
            check("tone2", tone2, e.t2);
            check("vol0", vol0, e.v0);
            check("vol1", vol1, e.v1);
            check("vol2", vol2, e.v2);
            check("vol3", vol3, e.v3);
            check("ctrl3", ctrl3, e.c);
            check("noise_clr", noise_clr, e.nz);
            chk_low = e.nz;
          end
        end
        if (!prev_rdy && ready)
          check("busy_ticks", ticks, BC);
        if (!ready && clk_en)
          ticks++;
        prev_rdy = ready;
      end
    end
  end

  task automatic en_ticks(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      g = 0;
      do begin
        @(posedge clk);
        g++;
      end while (!clk_en && g < 1000);
      if (!clk_en) begin
        $display("FAIL clk_en_timeout: got 0 expected 1");
        $fatal(1, "clk_en stuck");
      end
    end
    #1;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!ready && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!ready) begin
      $display("FAIL ready_timeout: got 0 expected 1");
      $fatal(1, "ready stuck low");
    end
  endtask

  task automatic strobe_on(input logic [7:0] b);
    din  = b;
    cs_n = 1'b0;
    wr_n = 1'b0;
  endtask

  task automatic strobe_off();
    cs_n = 1'b1;
    wr_n = 1'b1;
    din  = 8'($urandom);
  endtask

  task automatic do_write(input logic [7:0] b);
    bit nz;
    wait_ready();
    model_write(b, nz);
    push_exp(nz);
    strobe_on(b);
    en_ticks(1 + $urandom_range(0, 2));
    strobe_off();
    en_ticks(1);
  endtask

  initial begin
    logic [7:0] rb;
    bit nz;
    model_reset();

    // Reset with a strobe already low across reset exit.
    strobe_on(8'h90);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vol0", vol0, 4'hF);
    check("rst_vol1", vol1, 4'hF);
    check("rst_vol2", vol2, 4'hF);
    check("rst_vol3", vol3, 4'hF);
    check("rst_tone0", tone0, 0);
    check("rst_tone1", tone1, 0);
    check("rst_tone2", tone2, 0);
    check("rst_ctrl3", ctrl3, 0);
    check("rst_ready", ready, 1);
    check("rst_noise_clr", noise_clr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en_ticks(5);
    check("held_at_rst_ready", ready, 1);
    check("held_at_rst_vol0", vol0, 4'hF);
    strobe_off();
    en_ticks(1);

    // Tone latch + data.
    do_write(8'h8A);
    do_write(8'h3F);
    wait_ready();
    check("tone0_full", tone0, 10'h3FA);
    check("tone1_untouched", tone1, 0);
    check("tone2_untouched", tone2, 0);

    // Volume; latch stays on ch2 volume.
    do_write(8'hDF);
    do_write(8'h05);
    do_write(8'h07);
    wait_ready();
    check("vol2_latched", vol2, 4'h7);

    // Noise control twice.
    do_write(8'hE4);
    do_write(8'hE4);
    wait_ready();
    check("ctrl3_val", ctrl3, 3'b100);

    // Edge during busy dropped; held strobe not re-accepted.
    do_write(8'h90);
    en_ticks(10);
    strobe_on(8'h9F);
    wait_ready();
    en_ticks(4);
    check("held_strobe_ready", ready, 1);
    check("drop_vol0", vol0, 4'h0);
    strobe_off();
    en_ticks(1);

    // Randomized traffic with gappy clk_en.
    en_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_write(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        en_ticks(2);
        strobe_on(8'($urandom));
        en_ticks(1);
        strobe_off();
        en_ticks(1);
      end
    end
    en_rand = 1'b0;

    // Reset 5 ticks into busy.
    wait_ready();
    model_write(8'hA3, nz);
    push_exp(nz);
    strobe_on(8'hA3);
    en_ticks(1);
    strobe_off();
    en_ticks(5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_ready", ready, 1);
    check("midrst_tone1", tone1, 0);
    en_ticks(40);
    check("late_tone1", tone1, 0);
    check("late_ready", ready, 1);

    // Function after reset.
    rb = 8'hC9;
    do_write(rb);
    do_write(8'h2A);
    wait_ready();
    en_ticks(2);
    check("tone2_after_rst", tone2, 10'h2A9);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
